// File: rtl/curve_param_loader.sv
// Assembles KEY_W-bit curve parameters from a narrow valid/ready word stream.
// Writes each parameter to consecutive config addresses, then pulses done or flags err.
module curve_param_loader #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned KEY_W  = 256,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr,
  output logic [KEY_W-1:0]  data_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned WPP   = KEY_W / WORD_W;
  localparam int unsigned IDX_W = (WPP > 1) ? $clog2(WPP) : 1;

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic [IDX_W-1:0]    word_idx_q, word_idx_d;
  logic [KEY_W-1:0]    asm_q, asm_d;
  logic [KEY_W-1:0]    data_out_q, data_out_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic                s_ready_q, s_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic last_word;
  logic final_param;

  assign last_word   = (word_idx_q == IDX_W'(WPP - 1));
  assign final_param = (remaining_q == ADDR_W'(1));

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    word_idx_d  = word_idx_q;
    asm_d       = asm_q;
    data_out_d  = data_out_q;
    addr_d      = addr_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_addr_d  = start_addr;
          remaining_d = count;
          err_d       = 1'b0;
          word_idx_d  = '0;
          state_d     = (count == '0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        // s_ready_q is high for exactly the COLLECT cycles, so this is the handshake.
        if (s_valid && s_ready_q) begin
          for (int unsigned w = 0; w < WPP; w++) begin
            if (word_idx_q == IDX_W'(w)) asm_d[w*WORD_W +: WORD_W] = s_data;
          end
          if (s_last != (last_word && final_param)) begin
            // Framing mismatch: drop the partial parameter, no write.
            err_d      = 1'b1;
            word_idx_d = '0;
            state_d    = StDone;
          end else if (last_word) begin
            data_out_d = asm_d;
            addr_d     = cur_addr_q;
            word_idx_d = '0;
            state_d    = StWrite;
          end else begin
            word_idx_d = word_idx_q + IDX_W'(1);
          end
        end
      end
      StWrite: begin
        remaining_d = remaining_q - ADDR_W'(1);
        cur_addr_d  = cur_addr_q + ADDR_W'(1);
        word_idx_d  = '0;
        state_d     = final_param ? StDone : StCollect;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status outputs are registered copies of the upcoming state decode.
    s_ready_d = (state_d == StCollect);
    wr_en_d   = (state_d == StWrite);
    done_d    = (state_d == StDone);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      word_idx_q  <= '0;
      asm_q       <= '0;
      data_out_q  <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      word_idx_q  <= word_idx_d;
      asm_q       <= asm_d;
      data_out_q  <= data_out_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign wr_en    = wr_en_q;
  assign addr     = addr_q;
  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_curve_param_loader.sv
// Directed, table-driven bench for curve_param_loader: load scenarios with
// hand-set expectations plus count=0 and asynchronous-reset sequences.
module tb_curve_param_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   start_addr = '0;
  logic [3:0]   count = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         wr_en;
  logic [3:0]   addr;
  logic [255:0] data_out;
  logic         busy;
  logic         done;
  logic         err;

  curve_param_loader #(
    .WORD_W(32),
    .KEY_W (256),
    .ADDR_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .count     (count),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .wr_en     (wr_en),
    .addr      (addr),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] start_addr;
    logic [3:0] count;
    int         bad_word;    // stream index carrying a premature s_last, -1 for none
    bit         drop_last;   // omit s_last on the final word
    bit         gaps;        // insert s_valid bubbles
    bit         inj_start;   // pulse start mid-load
    int         exp_writes;
    bit         exp_err;
  } vec_t;

  vec_t vecs[8];

  // Monitor state, only touched by the main process.
  logic [3:0]   wr_addr_q[$];
  logic [255:0] wr_data_q[$];
  int           wr_cyc_q[$];
  int           done_cnt;
  int           done_cyc;
  logic         done_err;
  int           busy_gaps;
  int           proto_errs;
  bit           active;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (wr_en) begin
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(data_out);
      wr_cyc_q.push_back(cyc);
    end
    if (wr_en && s_ready) proto_errs++;
    if (active && done_cnt == 0 && !busy) busy_gaps++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
    end
  endtask

  function automatic logic [31:0] word_of(input int v, input int k);
    return {8'(v), 24'(k + 1)};
  endfunction

  function automatic logic [255:0] model(input int v, input int p);
    logic [255:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = word_of(v, p * 8 + j);
    return r;
  endfunction

  task automatic run_vec(input int vi);
    vec_t       v;
    int         nwords;
    int         last_k;
    int         k;
    int         budget;
    int         gc;
    int         hs[$];
    logic [3:0] ea;
    v = vecs[vi];
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cnt   = 0;
    done_cyc   = 0;
    done_err   = 1'b0;
    busy_gaps  = 0;
    proto_errs = 0;
    if (v.bad_word >= 0) begin
      nwords = v.bad_word + 1;
      last_k = v.bad_word;
    end else begin
      nwords = int'(v.count) * 8;
      last_k = v.drop_last ? -1 : nwords - 1;
    end

    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = v.start_addr;
    count      = v.count;
    @(posedge clk); #1;
    start  = 1'b0;
    active = 1'b1;
    s_valid = 1'b0;
    tick();
    check_int($sformatf("v%0d_busy_after_start", vi), int'(busy), 1);
    check_int($sformatf("v%0d_err_cleared", vi), int'(err), 0);
    @(posedge clk); #1;

    k = 0;
    budget = 0;
    gc = 0;
    while (k < nwords && budget < 1000) begin
      s_valid = v.gaps ? ((gc % 3) != 1) : 1'b1;
      gc++;
      s_data = word_of(vi, k);
      s_last = (k == last_k);
      if (v.inj_start && k == 3) begin
        start      = 1'b1;
        start_addr = 4'd9;
        count      = 4'd5;
      end else begin
        start = 1'b0;
      end
      tick();
      if (s_valid && s_ready) begin
        hs.push_back(cyc);
        k++;
      end
      @(posedge clk); #1;
      budget++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
    if (budget >= 1000) check_int($sformatf("v%0d_stream_timeout", vi), k, nwords);

    budget = 0;
    while (done_cnt == 0 && budget < 50) begin
      tick();
      budget++;
    end
    for (int i = 0; i < 3; i++) tick();
    active = 1'b0;

    check_int($sformatf("v%0d_n_writes", vi), wr_addr_q.size(), v.exp_writes);
    for (int i = 0; i < wr_addr_q.size() && i < v.exp_writes; i++) begin
      ea = v.start_addr + 4'(i);
      check_int($sformatf("v%0d_addr%0d", vi, i), int'(wr_addr_q[i]), int'(ea));
      check_vec($sformatf("v%0d_data%0d", vi, i), wr_data_q[i], model(vi, i));
      if (i * 8 + 7 < hs.size())
        check_int($sformatf("v%0d_wr_lat%0d", vi, i), wr_cyc_q[i], hs[i*8+7] + 1);
    end
    if (vi == 0 && wr_data_q.size() > 0)
      check_vec("v0_data_literal", wr_data_q[0],
                256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    if (vi == 1)
      for (int i = 1; i < wr_cyc_q.size(); i++)
        check_int($sformatf("v1_spacing%0d", i), wr_cyc_q[i] - wr_cyc_q[i-1], 9);
    check_int($sformatf("v%0d_done_cnt", vi), done_cnt, 1);
    check_int($sformatf("v%0d_done_err", vi), int'(done_err), int'(v.exp_err));
    if (hs.size() > 0)
      check_int($sformatf("v%0d_done_lat", vi), done_cyc, hs[hs.size()-1] + (v.exp_err ? 1 : 2));
    check_int($sformatf("v%0d_busy_gaps", vi), busy_gaps, 0);
    check_int($sformatf("v%0d_ready_in_write", vi), proto_errs, 0);
    check_int($sformatf("v%0d_err_held", vi), int'(err), int'(v.exp_err));
    check_int($sformatf("v%0d_idle_busy", vi), int'(busy), 0);
  endtask

  initial begin
    //           addr   cnt   bad  drop  gaps  inj  wr  err
    vecs[0] = '{4'd0,  4'd1, -1,  1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[1] = '{4'd0,  4'd6, -1,  1'b0, 1'b0, 1'b0, 6, 1'b0};
    vecs[2] = '{4'd15, 4'd2, -1,  1'b0, 1'b1, 1'b0, 2, 1'b0};
    vecs[3] = '{4'd0,  4'd2,  2,  1'b0, 1'b0, 1'b0, 0, 1'b1};
    vecs[4] = '{4'd3,  4'd2, -1,  1'b1, 1'b0, 1'b0, 1, 1'b1};
    vecs[5] = '{4'd5,  4'd1, -1,  1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[6] = '{4'd7,  4'd3,  15, 1'b0, 1'b0, 1'b0, 1, 1'b1};
    vecs[7] = '{4'd2,  4'd1, -1,  1'b0, 1'b0, 1'b1, 1, 1'b0};
    active = 1'b0;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_int("rst_s_ready", int'(s_ready), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_wr_en", int'(wr_en), 0);
    check_int("rst_done_err", int'({done, err}), 0);
    check_vec("rst_addr_data", {addr, data_out[251:0]}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // count == 0: straight to DONE, no stream traffic.
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = 4'd4;
    count = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_int("c0_done", int'(done), 1);
    check_int("c0_wr_en", int'(wr_en), 0);
    check_int("c0_s_ready", int'(s_ready), 0);
    @(negedge clk);
    check_int("c0_done_after", int'(done), 0);
    check_int("c0_busy_after", int'(busy), 0);
    check_int("c0_s_ready_after", int'(s_ready), 0);

    // Asynchronous reset in the middle of COLLECT.
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = 4'd0;
    count = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1;
      s_data  = 32'hA000_0000 + 32'(k);
      @(posedge clk); #1;
    end
    #1;
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    check_int("arst_s_ready", int'(s_ready), 0);
    check_int("arst_busy", int'(busy), 0);
    check_int("arst_wr_en", int'(wr_en), 0);
    check_int("arst_done_err", int'({done, err}), 0);
    check_int("arst_addr", int'(addr), 0);
    check_vec("arst_data", data_out, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_int($sformatf("arst_no_write%0d", i), int'(wr_en), 0);
    end
    rst_n = 1'b1;
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/curve_param_loader.md
Name: curve_param_loader

Overview:
- Initiator side of the curve-parameter configuration write port (wr_en / addr / data_in) that feeds the curve configuration register file ahead of the ECDSA datapath.
- Accepts parameter words over a narrow valid/ready stream and assembles each 256-bit parameter.
- Issues one single-cycle register write per assembled parameter to consecutive addresses, then reports completion or a framing error.

Parameters:
- WORD_W, 32, stream word width; KEY_W must be an exact multiple of it.
- KEY_W, 256, width of one curve parameter (data_out width).
- ADDR_W, 4, configuration address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle load request; honoured only in IDLE
- start_addr  in  ADDR_W  first config address to write
- count  in  ADDR_W  number of parameters to load (0..15)
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid & s_ready
- s_data  in  WORD_W  stream word, least-significant word of each parameter first
- s_last  in  1  marks the final word of the final parameter
- wr_en  out  1  config write strobe, one cycle per parameter
- addr  out  ADDR_W  config write address
- data_out  out  KEY_W  config write data; connects to the register file's data_in
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  framing error flag; held until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; s_ready, wr_en, busy, done and err are 0; addr=0; data_out=0; all counters 0. The block is immediately ready for start after rst_n deasserts.
- All outputs are registered. WPP = KEY_W/WORD_W = 8 words per parameter.
- IDLE:
  - start=1 latches cur_addr=start_addr and remaining=count, clears err, sets busy=1 and word_idx=0.
  - Next state is COLLECT, or DONE when count==0.
  - start while not in IDLE is ignored.
- COLLECT:
  - s_ready=1.
  - Each handshake writes s_data into assembly bits [word_idx*WORD_W +: WORD_W] and increments word_idx.
  - Handshake with word_idx==WPP-1 goes to WRITE.
  - Framing check on every handshake: s_last must equal (word_idx==WPP-1 && remaining==1).
  - On a mismatch, set err=1, discard the partial parameter, and go to DONE with no write.
  - s_ready drops on the cycle after the final-word handshake.
- WRITE (one cycle):
  - wr_en=1, addr=cur_addr, data_out=assembled word; s_ready=0.
  - Then remaining decrements, cur_addr increments modulo 2^ADDR_W (15 wraps to 0), and word_idx=0.
  - Next state is DONE if remaining becomes 0, else COLLECT.
- DONE (one cycle): done=1, busy=0 on exit; return to IDLE.
- wr_en is 0 in every state except WRITE. data_out and addr hold their last written values outside WRITE.
- Latency:
  - Final-word handshake in cycle t gives wr_en in t+1 and COLLECT (s_ready=1) again in t+2.
  - The last parameter gives done in t+2.
  - Minimum load time is count*(WPP+1)+1 cycles after start with a gap-free stream.
- s_valid gaps stall COLLECT indefinitely; there is no timeout.
- A reset mid-operation aborts immediately. No wr_en is issued after rst_n falls, and parameters already written remain in the register file.

Test Plan:
- Load p: start, start_addr=0, count=1, then 8 words 0x00000001..0x00000008 (s_last on the 8th) -> one wr_en, addr=0, data_out=0x00000008_00000007_..._00000001; done exactly 2 cycles after the last handshake; err=0.
- Full curve: start_addr=0, count=6, 48 gap-free words -> 6 wr_en pulses at addr 0..5, each separated by 9 cycles; busy high throughout; a single done.
- Address wrap plus stalls: start_addr=15, count=2, random s_valid gaps -> writes at addr 15 then 0 with correct data; nothing is written while stalled.
- Framing errors:
  - s_last on word 3 of parameter 1 (count=2) -> no wr_en, err=1, done pulse.
  - s_last missing on the final word -> err=1, done with no final write.
  - err clears on the next start.
- count=0 and start-while-busy:
  - start with count=0 -> done one cycle after IDLE, no wr_en, s_ready stays 0.
  - A second start during a load is ignored; addresses are unchanged.
- Async reset: assert rst_n=0 mid-COLLECT with no clock edge -> all outputs 0 immediately; after release, a fresh load of count=1 works correctly.
